// File: rtl/core_input_buf_pkg.sv
// core_input_buf_pkg
//   Shared definitions for the core input buffer: slot state encodings,
//   block geometry, operation-code width and the {ctx,seq} slot-index helper.
//   Optional feature macro: CORE_INPUT_ERR_EN (consumed by the files that
//   import this package; nothing here depends on it).
package core_input_buf_pkg;

  // Width of the block operation code is BLK_OP_MSB+1.
  localparam int BLK_OP_MSB  = 3;
  localparam int BLOCK_WORDS = 16;
  localparam int NUM_SLOTS   = 4;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FILL  = 2'd1,
    SLOT_FULL  = 2'd2,
    SLOT_BUSY  = 2'd3
  } slot_state_e;

  // Slot index is {ctx, seq}; ctx is the upper bit.
  function automatic logic [1:0] slot_idx(input logic ctx, input logic seq);
    return {ctx, seq};
  endfunction

endpackage

// File: rtl/core_input_slot_fsm.sv
// core_input_slot_fsm
//   Per-slot fill/claim state machine plus the slot's blk_op register.
//   Optional feature macro: CORE_INPUT_ERR_EN adds an expected-address
//   counter and a one-cycle protocol-error event output.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wr_hit_i           write strobe addressed to this slot
//   last_i             the write carries the final word of the block
//   wr_addr_i          word index of the write (error build only)
//   blk_op_i           operation code captured on the final word
//   rd_start_hit_i     claim request addressed to this slot
//   rd_done_hit_i      release request addressed to this slot
//   state_o            current slot state
//   wr_accept_o        this cycle's write may be stored in memory
//   blk_op_o           operation code of the last completed block
//   err_event_o        protocol violation this cycle (error build only)
module core_input_slot_fsm
  import core_input_buf_pkg::*;
#(
  parameter int BLK_OP_WIDTH = BLK_OP_MSB + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_hit_i,
  input  logic                    last_i,
`ifdef CORE_INPUT_ERR_EN
  input  logic [3:0]              wr_addr_i,
`endif
  input  logic [BLK_OP_WIDTH-1:0] blk_op_i,
  input  logic                    rd_start_hit_i,
  input  logic                    rd_done_hit_i,
  output slot_state_e             state_o,
  output logic                    wr_accept_o,
`ifdef CORE_INPUT_ERR_EN
  output logic                    err_event_o,
`endif
  output logic [BLK_OP_WIDTH-1:0] blk_op_o
);

  slot_state_e             state_q, state_d;
  logic [BLK_OP_WIDTH-1:0] blk_op_q, blk_op_d;
  logic                    wr_accept;

  // Only an EMPTY or FILL slot takes data; anything else is dropped.
  assign wr_accept = wr_hit_i && ((state_q == SLOT_EMPTY) || (state_q == SLOT_FILL));

  always_comb begin
    state_d  = state_q;
    blk_op_d = blk_op_q;
    case (state_q)
      SLOT_EMPTY: if (wr_hit_i) state_d = last_i ? SLOT_FULL : SLOT_FILL;
      SLOT_FILL:  if (wr_hit_i && last_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (rd_start_hit_i) state_d = SLOT_BUSY;
      SLOT_BUSY:  if (rd_done_hit_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (wr_accept && last_i) blk_op_d = blk_op_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      blk_op_q <= '0;
    end else begin
      state_q  <= state_d;
      blk_op_q <= blk_op_d;
    end
  end

  assign state_o     = state_q;
  assign wr_accept_o = wr_accept;
  assign blk_op_o    = blk_op_q;

`ifdef CORE_INPUT_ERR_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_event;
  logic       start_ok, done_ok;

  assign start_ok = rd_start_hit_i && (state_q == SLOT_FULL);
  assign done_ok  = rd_done_hit_i  && (state_q == SLOT_BUSY);

  always_comb begin
    cnt_d     = cnt_q;
    err_event = 1'b0;
    if (wr_accept) begin
      if (wr_addr_i != cnt_q) err_event = 1'b1;
      if (last_i) begin
        cnt_d = '0;
        if (wr_addr_i != 4'(BLOCK_WORDS - 1)) err_event = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (wr_hit_i && !wr_accept) err_event = 1'b1;
    // A start/done pair shares one selector, so exactly one of them can be
    // legal; the cycle is only an error when neither request applies.
    if ((rd_start_hit_i || rd_done_hit_i) && !(start_ok || done_ok)) err_event = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_event_o = err_event;
`endif

endmodule

// File: rtl/core_input_buf.sv
// core_input_buf
//   Core-side receiver for 16-word message blocks. Four thread slots
//   ({ctx,seq}) share one 64-word memory; each slot has its own fill/claim
//   state machine. The MD5 engine claims FULL slots, reads words at random
//   and releases them.
//   Optional feature macro: CORE_INPUT_ERR_EN adds the sticky err output.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   core_wr_en/core_wr_addr/din   word write from the distribution stage
//   core_input_ctx/core_input_seq target slot of the write
//   core_blk_op, set_input_ready  block op code / final-word marker
//   slot_free, slot_ready         registered per-slot EMPTY / FULL flags
//   rd_start, rd_done             claim a FULL slot / release a BUSY slot
//   rd_ctx, rd_seq                slot selector for claim, release and read
//   rd_en, rd_addr, dout          registered word read port
//   rd_blk_op                     op code of the most recently claimed slot
//   err                           sticky protocol error (error build only)
module core_input_buf
  import core_input_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BLK_OP_WIDTH = BLK_OP_MSB + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    core_wr_en,
  input  logic [3:0]              core_wr_addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    core_input_ctx,
  input  logic                    core_input_seq,
  input  logic [BLK_OP_WIDTH-1:0] core_blk_op,
  input  logic                    set_input_ready,
  output logic [3:0]              slot_free,
  output logic [3:0]              slot_ready,
  input  logic                    rd_start,
  input  logic                    rd_done,
  input  logic                    rd_ctx,
  input  logic                    rd_seq,
  input  logic                    rd_en,
  input  logic [3:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]   dout,
`ifdef CORE_INPUT_ERR_EN
  output logic                    err,
`endif
  output logic [BLK_OP_WIDTH-1:0] rd_blk_op
);

  localparam int MEM_DEPTH = NUM_SLOTS * BLOCK_WORDS;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [1:0]              wr_slot, rd_slot;
  slot_state_e             slot_state [NUM_SLOTS];
  logic [BLK_OP_WIDTH-1:0] slot_blk_op [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    wr_accept;
`ifdef CORE_INPUT_ERR_EN
  logic [NUM_SLOTS-1:0]    err_event;
  logic                    err_q;
`endif
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [BLK_OP_WIDTH-1:0] rd_blk_op_q;
  logic [3:0]              slot_free_q, slot_free_d;
  logic [3:0]              slot_ready_q, slot_ready_d;

  assign wr_slot = slot_idx(core_input_ctx, core_input_seq);
  assign rd_slot = slot_idx(rd_ctx, rd_seq);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    core_input_slot_fsm #(
      .BLK_OP_WIDTH(BLK_OP_WIDTH)
    ) u_fsm (
      .clk           (CLK),
      .rst           (RST),
      .wr_hit_i      (core_wr_en && (wr_slot == 2'(gi))),
      .last_i        (set_input_ready),
`ifdef CORE_INPUT_ERR_EN
      .wr_addr_i     (core_wr_addr),
      .err_event_o   (err_event[gi]),
`endif
      .blk_op_i      (core_blk_op),
      .rd_start_hit_i(rd_start && (rd_slot == 2'(gi))),
      .rd_done_hit_i (rd_done && (rd_slot == 2'(gi))),
      .state_o       (slot_state[gi]),
      .wr_accept_o   (wr_accept[gi]),
      .blk_op_o      (slot_blk_op[gi])
    );
  end

  // Block memory: no reset, one write and one registered read port.
  always_ff @(posedge CLK) begin
    if (|wr_accept) mem[{wr_slot, core_wr_addr}] <= din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        dout_q <= '0;
    else if (rd_en) dout_q <= mem[{rd_slot, rd_addr}];
  end

  always_comb begin
    slot_free_d  = '0;
    slot_ready_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_free_d[i]  = (slot_state[i] == SLOT_EMPTY);
      slot_ready_d[i] = (slot_state[i] == SLOT_FULL);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_free_q  <= 4'hF;
      slot_ready_q <= 4'h0;
      rd_blk_op_q  <= '0;
    end else begin
      slot_free_q  <= slot_free_d;
      slot_ready_q <= slot_ready_d;
      if (rd_start && (slot_state[rd_slot] == SLOT_FULL))
        rd_blk_op_q <= slot_blk_op[rd_slot];
    end
  end

`ifdef CORE_INPUT_ERR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_q | (|err_event);
  end
  assign err = err_q;
`endif

  assign dout       = dout_q;
  assign rd_blk_op  = rd_blk_op_q;
  assign slot_free  = slot_free_q;
  assign slot_ready = slot_ready_q;

endmodule
